// File: rtl/right_barrel_shifter_pipe.sv
// Pipelined logarithmic right barrel shifter (logical or arithmetic), one shift-amount bit per stage.
// Latency: STAGES = log2(DATA_WIDTH) registers; an item accepted on edge t is on ODATA after edge t+STAGES-1.
// Backpressure: OVALID & ~OREADY freezes the whole pipe; IREADY = ~OVALID | OREADY (combinational).
module right_barrel_shifter_pipe #(
    parameter int DATA_WIDTH = 32,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   IVALID,
    output logic                   IREADY,
    input  logic [DATA_WIDTH-1:0]  IDATA,
    input  logic [SHAMT_WIDTH-1:0] SHAMT,
    input  logic                   ARITH,
    output logic [DATA_WIDTH-1:0]  ODATA,
    output logic                   OVALID,
    input  logic                   OREADY
);
    localparam int STAGES = SHAMT_WIDTH;

    // Stage registers: every item carries its own amount and fill bit down the pipe,
    // so consecutive items with different modes never interfere.
    logic                   vld_q  [STAGES];
    logic [DATA_WIDTH-1:0]  dat_q  [STAGES];
    logic                   fill_q [STAGES];
    logic [SHAMT_WIDTH-1:0] amt_q  [STAGES];

    // What each stage sees at its input, and the shifted word it will capture.
    logic                   vld_in  [STAGES];
    logic [DATA_WIDTH-1:0]  dat_in  [STAGES];
    logic                   fill_in [STAGES];
    logic [SHAMT_WIDTH-1:0] amt_in  [STAGES];
    logic [DATA_WIDTH-1:0]  dat_nxt [STAGES];

    // Single global advance: bubbles are not squeezed out, the pipe moves as one.
    logic en;

    assign en     = ~vld_q[STAGES-1] | OREADY;
    assign IREADY = en;
    assign OVALID = vld_q[STAGES-1];
    assign ODATA  = dat_q[STAGES-1];

    // Route stage inputs: stage 0 from the ports, later stages from their predecessor
    always_comb begin
        vld_in[0]  = IVALID;
        dat_in[0]  = IDATA;
        fill_in[0] = IDATA[DATA_WIDTH-1] & ARITH;
        amt_in[0]  = SHAMT;
        for (int s = 1; s < STAGES; s++) begin
            vld_in[s]  = vld_q[s-1];
            dat_in[s]  = dat_q[s-1];
            fill_in[s] = fill_q[s-1];
            amt_in[s]  = amt_q[s-1];
        end
    end

    // Stage s shifts right by 2**s when bit s of the item's amount is set, filling with its fill bit
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            dat_nxt[s] = dat_in[s];
            if (amt_in[s][s]) begin
                dat_nxt[s] = (dat_in[s] >> (1 << s))
                           | (~({DATA_WIDTH{1'b1}} >> (1 << s)) & {DATA_WIDTH{fill_in[s]}});
            end
        end
    end

    // Advance all stages together when enabled; reset drops every in-flight item
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]  <= 1'b0;
                dat_q[s]  <= '0;
                fill_q[s] <= 1'b0;
                amt_q[s]  <= '0;
            end
        end else if (en) begin
            for (int s = 0; s < STAGES; s++) begin
                vld_q[s]  <= vld_in[s];
                dat_q[s]  <= dat_nxt[s];
                fill_q[s] <= fill_in[s];
                amt_q[s]  <= amt_in[s];
            end
        end
    end

endmodule

// File: tb/tb_right_barrel_shifter_pipe.sv
// Directed bench for right_barrel_shifter_pipe: hand-computed shift vectors streamed through the pipe.
// Latency: expects each item on ODATA exactly STAGES-1 edges after its accept edge when unstalled.
// Backpressure: exercises random OREADY, fill under stall, and asynchronous reset mid-flight.
module tb_right_barrel_shifter_pipe;
    localparam int DW     = 32;
    localparam int SW     = 5;
    localparam int STAGES = 5;
    localparam int NV     = 24;

    logic          CLK = 1'b0;
    logic          RST;
    logic          IVALID;
    logic          IREADY;
    logic [DW-1:0] IDATA;
    logic [SW-1:0] SHAMT;
    logic          ARITH;
    logic [DW-1:0] ODATA;
    logic          OVALID;
    logic          OREADY;

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  sh;
        logic        ar;
        logic [31:0] e;
    } vec_t;

    typedef struct packed {
        logic [31:0] e;
        logic [31:0] cyc;
    } exp_t;

    // data, shift, arith, expected (worked out by hand)
    vec_t vt [NV] = '{
        '{32'h80000000, 5'd31, 1'b0, 32'h00000001},
        '{32'h80000000, 5'd31, 1'b1, 32'hFFFFFFFF},
        '{32'h12345678, 5'd0,  1'b0, 32'h12345678},
        '{32'hF0000000, 5'd4,  1'b1, 32'hFF000000},
        '{32'h12345678, 5'd0,  1'b1, 32'h12345678},
        '{32'h12345678, 5'd4,  1'b0, 32'h01234567},
        '{32'h12345678, 5'd4,  1'b1, 32'h01234567},
        '{32'h87654321, 5'd8,  1'b0, 32'h00876543},
        '{32'h87654321, 5'd8,  1'b1, 32'hFF876543},
        '{32'h87654321, 5'd16, 1'b1, 32'hFFFF8765},
        '{32'h87654321, 5'd1,  1'b0, 32'h43B2A190},
        '{32'h87654321, 5'd1,  1'b1, 32'hC3B2A190},
        '{32'hFFFFFFFF, 5'd31, 1'b0, 32'h00000001},
        '{32'h7FFFFFFF, 5'd31, 1'b1, 32'h00000000},
        '{32'hA5A5A5A5, 5'd3,  1'b1, 32'hF4B4B4B4},
        '{32'hA5A5A5A5, 5'd3,  1'b0, 32'h14B4B4B4},
        '{32'h00000001, 5'd1,  1'b0, 32'h00000000},
        '{32'hC0000000, 5'd30, 1'b1, 32'hFFFFFFFF},
        '{32'hC0000000, 5'd30, 1'b0, 32'h00000003},
        '{32'h80000000, 5'd5,  1'b1, 32'hFC000000},
        '{32'hDEADBEEF, 5'd12, 1'b0, 32'h000DEADB},
        '{32'hDEADBEEF, 5'd12, 1'b1, 32'hFFFDEADB},
        '{32'hDEADBEEF, 5'd28, 1'b1, 32'hFFFFFFFD},
        '{32'h12345678, 5'd20, 1'b1, 32'h00000123}
    };

    exp_t        q_exp [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          vi       = 0;
    int          n_out    = 0;
    int          seen_vld = 0;
    bit          stall_prev = 1'b0;
    bit          last_acc   = 1'b0;
    logic [31:0] data_prev  = '0;

    right_barrel_shifter_pipe #(.DATA_WIDTH(DW)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .IVALID (IVALID),
        .IREADY (IREADY),
        .IDATA  (IDATA),
        .SHAMT  (SHAMT),
        .ARITH  (ARITH),
        .ODATA  (ODATA),
        .OVALID (OVALID),
        .OREADY (OREADY)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs just after an edge, sample before the next, then log any accept.
    task automatic step(input bit send, input bit ordy, input bit lat_chk);
        exp_t x;
        bit   acc;
        bit   emit;
        bit   rdy_exp;
        IVALID = send && (vi < NV);
        if (vi < NV) begin
            IDATA = vt[vi].d;
            SHAMT = vt[vi].sh;
            ARITH = vt[vi].ar;
        end else begin
            IDATA = '0;
            SHAMT = '0;
            ARITH = 1'b0;
        end
        OREADY = ordy;
        #1;
        rdy_exp = !OVALID || OREADY;
        check("iready_rule", {31'b0, IREADY}, {31'b0, rdy_exp});
        if (stall_prev) begin
            check("hold_valid", {31'b0, OVALID}, 32'd1);
            check("hold_data", ODATA, data_prev);
        end
        acc  = IVALID && IREADY;
        emit = OVALID && OREADY;
        if (OVALID) seen_vld++;
        if (emit) begin
            n_out++;
            if (q_exp.size() > 0) begin
                x = q_exp.pop_front();
                check("odata", ODATA, x.e);
                if (lat_chk) check("latency", 32'(cyc) - x.cyc, 32'(STAGES - 1));
            end
        end
        stall_prev = OVALID && !OREADY;
        data_prev  = ODATA;
        last_acc   = acc;
        @(posedge CLK);
        #1;
        if (acc) begin
            x.e   = vt[vi].e;
            x.cyc = 32'(cyc);
            q_exp.push_back(x);
            vi++;
        end
    endtask

    task automatic drain(input string tag, input int expect_n, input bit lat_chk);
        int budget = 0;
        while (q_exp.size() > 0 && budget < 300) begin
            step(1'b0, 1'b1, lat_chk);
            budget++;
        end
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
        check({tag, "_count"}, 32'(n_out), 32'(expect_n));
        check({tag, "_left"}, 32'(q_exp.size()), 32'd0);
    endtask

    task automatic restart();
        vi = 0;
        n_out = 0;
        stall_prev = 1'b0;
        q_exp.delete();
    endtask

    initial begin
        int b;
        RST    = 1'b1;
        IVALID = 1'b0;
        IDATA  = '0;
        SHAMT  = '0;
        ARITH  = 1'b0;
        OREADY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_ovalid", {31'b0, OVALID}, 32'd0);
        check("rst_odata", ODATA, 32'd0);
        check("rst_iready", {31'b0, IREADY}, 32'd1);
        RST = 1'b0;

        // Idle after release: nothing may appear
        seen_vld = 0;
        repeat (8) step(1'b0, 1'b1, 1'b0);
        check("idle_ovalid", 32'(seen_vld), 32'd0);

        // Back-to-back stream, OREADY held high
        restart();
        b = 0;
        while (vi < NV && b < 200) begin
            step(1'b1, 1'b1, 1'b1);
            b++;
        end
        drain("stream", NV, 1'b1);

        // Stream under random backpressure
        restart();
        b = 0;
        while (vi < NV && b < 500) begin
            step(1'b1, ($urandom_range(0, 1) == 1), 1'b0);
            b++;
        end
        drain("bp", NV, 1'b0);

        // Fill with the output stalled from an empty pipe
        restart();
        repeat (8) step(1'b1, 1'b0, 1'b0);
        check("fill_accepts", 32'(vi), 32'(STAGES));
        check("fill_iready", {31'b0, IREADY}, 32'd0);
        drain("fill", STAGES, 1'b0);

        // Asynchronous reset mid-cycle with a full, stalled pipe
        restart();
        repeat (7) step(1'b1, 1'b0, 1'b0);
        #3;
        RST = 1'b1;
        #1;
        check("arst_ovalid", {31'b0, OVALID}, 32'd0);
        check("arst_odata", ODATA, 32'd0);
        check("arst_iready", {31'b0, IREADY}, 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Reset while three items are in flight: they must vanish
        restart();
        repeat (3) step(1'b1, 1'b1, 1'b0);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        restart();
        vi = 9;
        step(1'b1, 1'b1, 1'b1);
        check("accept_after_rst", {31'b0, last_acc}, 32'd1);
        IVALID = 1'b0;
        vi = NV;
        repeat (10) step(1'b0, 1'b1, 1'b1);
        check("rst_drop_count", 32'(n_out), 32'd1);
        check("rst_drop_left", 32'(q_exp.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
